gcn_aggregation_scheduler: RTL and testbench
============================================

GCN_AGGREGATION_SCHEDULER -- requirements
Module: gcn_aggregation_scheduler

Interface
REQ-001 The block SHALL have parameter FEATURE_ROWS, default 6: node count, i.e. rows in the transformed-feature memory and in the accumulation memory.
REQ-002 The block SHALL have parameter FEATURE_WIDTH, default $clog2(FEATURE_ROWS): row-index width.
REQ-003 The block SHALL have parameter EDGE_CNT_WIDTH, default 8: accepted-edge counter width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: single-cycle pulse that begins a run.
REQ-007 The block SHALL have ports edge_valid (input, 1), edge_ready (output, 1), edge_src (input, FEATURE_WIDTH), edge_dst (input, FEATURE_WIDTH) and edge_last (input, 1), forming the adjacency edge stream.
REQ-008 The block SHALL have port fm_rd_row, output, FEATURE_WIDTH: read row for the transformed-feature memory; that memory has 1-cycle registered read latency.
REQ-009 The block SHALL have ports acc_en (output, 1) and acc_write_row (output, FEATURE_WIDTH), driving the accumulation memory's accumulate-enable and write-row inputs.
REQ-010 The block SHALL have port acc_read_row, output, FEATURE_WIDTH: read row of the accumulation memory, whose read is combinational.
REQ-011 The block SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_row (output, FEATURE_WIDTH), forming the result row stream.
REQ-012 The block SHALL have ports busy (output, 1), done (output, 1), err (output, 1, sticky) and edge_count (output, EDGE_CNT_WIDTH).

Function
REQ-013 The FSM SHALL have exactly the states IDLE, EDGE_WAIT, FETCH, ACCUM, DRAIN and DONE.
REQ-014 IDLE: start=1 SHALL go to EDGE_WAIT, clear edge_count and clear err; start in any other state SHALL be ignored.
REQ-015 EDGE_WAIT: edge_ready SHALL be 1; all other states SHALL drive edge_ready=0.
REQ-016 On an EDGE_WAIT handshake with edge_src<FEATURE_ROWS and edge_dst<FEATURE_ROWS, the block SHALL register src, dst and last, drive fm_rd_row=src from the next cycle, and go to FETCH.
REQ-017 On an EDGE_WAIT handshake with either index >=FEATURE_ROWS, the block SHALL drop the edge, set err, not increment edge_count, and go to DRAIN if edge_last=1, else stay in EDGE_WAIT.
REQ-018 FETCH SHALL last exactly one cycle, covering memory read latency, then go to ACCUM.
REQ-019 ACCUM SHALL last one cycle with acc_en=1, acc_write_row=registered dst, and edge_count incremented, saturating at all-ones.
REQ-020 ACCUM SHALL go to DRAIN if the registered last=1, else to EDGE_WAIT.
REQ-021 acc_en SHALL be 1 only in ACCUM, giving a minimum of 3 cycles per edge.
REQ-022 fm_rd_row SHALL hold its value outside FETCH/ACCUM.
REQ-023 Self-loops (src==dst) and repeated dst SHALL be processed normally, with no hazard, because each accumulate completes before the next edge is accepted.
REQ-024 On DRAIN entry, the row counter SHALL be 0; in DRAIN, out_valid=1 and out_row=acc_read_row=row counter.
REQ-025 In DRAIN, out_valid=1 and out_row SHALL be held stable until out_ready=1.
REQ-026 In DRAIN, out_valid && out_ready SHALL advance the row counter; the handshake on row FEATURE_ROWS-1 SHALL go to DONE with no wrap.
REQ-027 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 err and edge_count SHALL hold their values from the end of a run until the next accepted start.

Reset
REQ-030 While rst_n=0, asynchronously, the block SHALL force state=IDLE, with edge_ready, acc_en, out_valid, busy, done and err all 0.
REQ-031 While rst_n=0, fm_rd_row, acc_write_row, acc_read_row, out_row, edge_count and the row counter SHALL be 0.
REQ-032 Reset SHALL abort any run mid-operation without issuing a partial acc_en pulse.
REQ-033 After rst_n deasserts, start SHALL be honoured from the first rising clock edge.

Verification
REQ-034 Scenario: start; edges (0->1),(2->1),(1->1 last) -> acc_en pulses with acc_write_row=1 three times, fm_rd_row 0,2,1; edge_count=3; err=0.
REQ-035 Scenario: DRAIN with out_ready=1 constantly -> out_row 0..5 on consecutive cycles, then done=1 for 1 cycle, busy=0 the next cycle.
REQ-036 Scenario: out_ready toggling 1/0 -> each out_row held until accepted; no row skipped or repeated; exactly 6 handshakes.
REQ-037 Scenario: edge (7->0) with FEATURE_ROWS=6, then (3->4 last) -> first edge dropped with no acc_en; err=1; edge_count=1; one acc_en with row 4.
REQ-038 Scenario: rst_n=0 asserted during ACCUM of the 2nd edge -> outputs reset immediately; next start begins a clean run with edge_count=0.
REQ-039 Scenario: start pulsed while busy, and edge_valid=1 outside EDGE_WAIT -> no effect; edge_ready=0; state sequence unchanged.

Source files
------------

// File: rtl/gcn_aggregation_scheduler.sv
// ============================================================================
//  Module   : gcn_aggregation_scheduler
//  Brief    : Sequences GCN neighbour aggregation. Consumes an adjacency edge
//             stream, reads the source row from the transformed-feature
//             memory, pulses an accumulate into the destination row, then
//             streams every accumulated row out.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcn_aggregation_scheduler #(
    parameter int FEATURE_ROWS   = 6,
    parameter int FEATURE_WIDTH  = $clog2(FEATURE_ROWS),
    parameter int EDGE_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      edge_valid,
    output logic                      edge_ready,
    input  logic [FEATURE_WIDTH-1:0]  edge_src,
    input  logic [FEATURE_WIDTH-1:0]  edge_dst,
    input  logic                      edge_last,
    output logic [FEATURE_WIDTH-1:0]  fm_rd_row,
    output logic                      acc_en,
    output logic [FEATURE_WIDTH-1:0]  acc_write_row,
    output logic [FEATURE_WIDTH-1:0]  acc_read_row,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [FEATURE_WIDTH-1:0]  out_row,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [EDGE_CNT_WIDTH-1:0] edge_count
);

    localparam logic [FEATURE_WIDTH:0]   c_ROWS     = (FEATURE_WIDTH+1)'(FEATURE_ROWS);
    localparam logic [FEATURE_WIDTH-1:0] c_LAST_ROW = FEATURE_WIDTH'(FEATURE_ROWS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EDGE_WAIT = 3'd1,
        FETCH     = 3'd2,
        ACCUM     = 3'd3,
        DRAIN     = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [FEATURE_WIDTH-1:0]    r_src;
    logic [FEATURE_WIDTH-1:0]    r_dst;
    logic                        r_last;
    logic [FEATURE_WIDTH-1:0]    r_row;
    logic                        r_err;
    logic [EDGE_CNT_WIDTH-1:0]   r_edge_count;

    logic w_edge_hs;
    logic w_edge_ok;
    logic w_out_hs;
    logic w_last_row;

    // Both indices must address a real node, else the edge is dropped.
    assign w_edge_ok  = ({1'b0, edge_src} < c_ROWS) && ({1'b0, edge_dst} < c_ROWS);
    assign w_edge_hs  = (r_state == EDGE_WAIT) && edge_valid;
    assign w_out_hs   = (r_state == DRAIN) && out_ready;
    assign w_last_row = (r_row == c_LAST_ROW);

    assign edge_ready    = (r_state == EDGE_WAIT);
    assign acc_en        = (r_state == ACCUM);
    assign out_valid     = (r_state == DRAIN);
    assign done          = (r_state == DONE);
    assign busy          = (r_state != IDLE);
    assign fm_rd_row     = r_src;
    assign acc_write_row = r_dst;
    assign acc_read_row  = r_row;
    assign out_row       = r_row;
    assign err           = r_err;
    assign edge_count    = r_edge_count;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; each accepted edge walks FETCH then ACCUM so its
    // accumulate retires before the next edge can be accepted.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (start) w_next = EDGE_WAIT;
            EDGE_WAIT: begin
                if (w_edge_hs) begin
                    if (w_edge_ok)      w_next = FETCH;
                    else if (edge_last) w_next = DRAIN;
                end
            end
            FETCH:     w_next = ACCUM;
            ACCUM:     w_next = r_last ? DRAIN : EDGE_WAIT;
            DRAIN:     if (w_out_hs && w_last_row) w_next = DONE;
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Edge capture, error/edge counting and drain row counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src        <= '0;
            r_dst        <= '0;
            r_last       <= 1'b0;
            r_row        <= '0;
            r_err        <= 1'b0;
            r_edge_count <= '0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_edge_count <= '0;
                r_err        <= 1'b0;
                r_row        <= '0;
            end
            if (w_edge_hs) begin
                if (w_edge_ok) begin
                    r_src  <= edge_src;
                    r_dst  <= edge_dst;
                    r_last <= edge_last;
                end else begin
                    r_err  <= 1'b1;
                end
            end
            if ((r_state == ACCUM) && (r_edge_count != {EDGE_CNT_WIDTH{1'b1}})) begin
                r_edge_count <= r_edge_count + 1'b1;
            end
            // Counter returns to zero on the final handshake, so every
            // DRAIN entry starts at row 0.
            if (w_out_hs) begin
                r_row <= w_last_row ? '0 : r_row + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gcn_aggregation_scheduler.sv
// ============================================================================
//  Module   : tb_gcn_aggregation_scheduler
//  Brief    : Self-checking bench for gcn_aggregation_scheduler with a
//             list-based reference model of accepted edges and drained rows.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gcn_aggregation_scheduler;

    localparam int ROWS = 6;
    localparam int FW   = 3;
    localparam int CW   = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          edge_valid = 1'b0;
    logic          edge_ready;
    logic [FW-1:0] edge_src = '0;
    logic [FW-1:0] edge_dst = '0;
    logic          edge_last = 1'b0;
    logic [FW-1:0] fm_rd_row;
    logic          acc_en;
    logic [FW-1:0] acc_write_row;
    logic [FW-1:0] acc_read_row;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [FW-1:0] out_row;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] edge_count;

    always #5 clk = ~clk;

    gcn_aggregation_scheduler #(
        .FEATURE_ROWS   (ROWS),
        .FEATURE_WIDTH  (FW),
        .EDGE_CNT_WIDTH (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .edge_valid    (edge_valid),
        .edge_ready    (edge_ready),
        .edge_src      (edge_src),
        .edge_dst      (edge_dst),
        .edge_last     (edge_last),
        .fm_rd_row     (fm_rd_row),
        .acc_en        (acc_en),
        .acc_write_row (acc_write_row),
        .acc_read_row  (acc_read_row),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_row       (out_row),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .edge_count    (edge_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // observations
    logic [5:0]    acc_q[$];
    logic [FW-1:0] out_q[$];
    int            out_cyc_q[$];
    int            cyc = 0;
    int            done_pulses = 0;
    int            hold_viol = 0;
    int            busy_viol = 0;
    int            ready_viol = 0;
    int            rowmatch_viol = 0;
    logic          prev_done = 1'b0;
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [FW-1:0] prev_row = '0;

    // stimulus edge list and model results
    logic [FW-1:0] e_src[$];
    logic [FW-1:0] e_dst[$];
    logic [5:0]    exp_q[$];

    // Passive monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (acc_en) acc_q.push_back({fm_rd_row, acc_write_row});
        if (out_valid && out_ready) begin
            out_q.push_back(out_row);
            out_cyc_q.push_back(cyc);
        end
        if (done) done_pulses++;
        if (prev_done && (busy || done)) busy_viol++;
        if (prev_valid && !prev_ready && out_valid && (out_row !== prev_row)) hold_viol++;
        if (edge_ready && (acc_en || out_valid || !busy)) ready_viol++;
        if (out_valid && (out_row !== acc_read_row)) rowmatch_viol++;
        prev_done  = done;
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_row   = out_row;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_edge(input logic [FW-1:0] s, input logic [FW-1:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        edge_valid = 1'b1;
        edge_src   = s;
        edge_dst   = d;
        edge_last  = l;
        for (int k = 0; k < 20; k++) begin
            if (edge_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        edge_valid = 1'b0;
        edge_last  = 1'b0;
        if (!ok) check("edge_ready_timeout", 32'd0, 32'd1);
    endtask

    // Starts a run (caller sits just after a rising edge), feeds the edge
    // list, drains and compares everything against the list-based model.
    // mode: 0 ready high, 1 ready toggling, 2 ready random,
    //       3 toggling plus stray start/edge_valid during the drain.
    task automatic do_run(input int mode, input string tag);
        int d0;
        int n_ok;
        logic e_err;
        int exp_cnt;
        acc_q.delete();
        out_q.delete();
        out_cyc_q.delete();
        d0 = done_pulses;

        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_start_busy"}, 32'(busy), 32'd1);
        check({tag, "_start_cnt"}, 32'(edge_count), 32'd0);
        check({tag, "_start_err"}, 32'(err), 32'd0);

        foreach (e_src[i]) send_edge(e_src[i], e_dst[i], i == e_src.size() - 1);

        for (int k = 0; k < 400 && done_pulses == d0; k++) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 2 == 0);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: begin
                    out_ready  = (k % 2 == 0);
                    start      = (k == 2);
                    edge_valid = 1'b1;
                    edge_src   = 3'd1;
                    edge_dst   = 3'd2;
                end
            endcase
            tick();
        end
        out_ready  = 1'b0;
        start      = 1'b0;
        edge_valid = 1'b0;
        tick();

        // reference model: accepted edges in order, error flag, saturating count
        exp_q.delete();
        n_ok  = 0;
        e_err = 1'b0;
        foreach (e_src[i]) begin
            if (e_src[i] < ROWS && e_dst[i] < ROWS) begin
                exp_q.push_back({e_src[i], e_dst[i]});
                n_ok++;
            end else begin
                e_err = 1'b1;
            end
        end
        exp_cnt = (n_ok > 255) ? 255 : n_ok;

        check({tag, "_done_pulses"}, 32'(done_pulses - d0), 32'd1);
        check({tag, "_acc_count"}, 32'(acc_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) check({tag, "_acc_src_dst"}, 32'(acc_q[i]), 32'(exp_q[i]));
        check({tag, "_out_count"}, 32'(out_q.size()), 32'(ROWS));
        for (int r = 0; r < ROWS; r++) check({tag, "_out_row"}, 32'(out_q[r]), 32'(r));
        if (mode == 0) check({tag, "_drain_span"}, 32'(out_cyc_q[ROWS-1] - out_cyc_q[0]), 32'(ROWS - 1));
        check({tag, "_edge_count"}, 32'(edge_count), 32'(exp_cnt));
        check({tag, "_err"}, 32'(err), 32'(e_err));
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // reset values
        #12;
        check("rst_edge_ready", 32'(edge_ready), 32'd0);
        check("rst_acc_en", 32'(acc_en), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rows", 32'({fm_rd_row, acc_write_row, acc_read_row, out_row}), 32'd0);
        check("rst_edge_count", 32'(edge_count), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // three edges into row 1, including a self loop; constant ready
        e_src = '{3'd0, 3'd2, 3'd1};
        e_dst = '{3'd1, 3'd1, 3'd1};
        do_run(0, "basic");

        // same edges, toggling ready during the drain
        do_run(1, "toggle");

        // out-of-range edge dropped, err sticky afterwards
        e_src = '{3'd7, 3'd3};
        e_dst = '{3'd0, 3'd4};
        do_run(2, "bad_idx");
        tick();
        tick();
        tick();
        check("err_sticky", 32'(err), 32'd1);
        check("cnt_sticky", 32'(edge_count), 32'd1);

        // stray start and edge_valid while busy
        e_src = '{3'd4, 3'd5};
        e_dst = '{3'd5, 3'd0};
        do_run(3, "stray");

        // reset during ACCUM of the second edge
        acc_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        send_edge(3'd1, 3'd2, 1'b0);
        send_edge(3'd3, 3'd4, 1'b0);
        for (int k = 0; k < 10 && !acc_en; k++) tick();
        check("pre_rst_acc_en", 32'(acc_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_acc_en", 32'(acc_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_edge_count", 32'(edge_count), 32'd0);
        check("mid_rst_rows", 32'({fm_rd_row, acc_write_row, out_row}), 32'd0);
        tick();
        tick();
        check("mid_rst_acc_seen", 32'(acc_q.size()), 32'd1);
        rst_n = 1'b1;
        e_src = '{3'd5, 3'd0};
        e_dst = '{3'd0, 3'd5};
        do_run(0, "post_rst");

        // randomized runs
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 6);
            e_src.delete();
            e_dst.delete();
            for (int i = 0; i < n; i++) begin
                e_src.push_back(FW'($urandom_range(0, 7)));
                e_dst.push_back(FW'($urandom_range(0, 7)));
            end
            do_run($urandom_range(0, 2), "rand");
            tick();
        end

        // edge counter saturation
        e_src.delete();
        e_dst.delete();
        for (int i = 0; i < 260; i++) begin
            e_src.push_back(FW'($urandom_range(0, ROWS - 1)));
            e_dst.push_back(FW'($urandom_range(0, ROWS - 1)));
        end
        do_run(0, "saturate");

        check("out_hold", 32'(hold_viol), 32'd0);
        check("done_one_cycle", 32'(busy_viol), 32'd0);
        check("edge_ready_outside", 32'(ready_viol), 32'd0);
        check("out_row_vs_read_row", 32'(rowmatch_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
